// File: rtl/cube_scan_sequencer_if.sv
// Handshake and data bundle between the scan sequencer, the move sequencer, the colour
// sensors and the solver. The sequencer uses the slave view; its environment uses master.
interface cube_scan_sequencer_if #(
  parameter int unsigned COLOR_W      = 3,
  parameter int unsigned NUM_STICKERS = 48
);
  localparam int unsigned IdxW = (NUM_STICKERS > 1) ? $clog2(NUM_STICKERS) : 1;

  logic                                start;
  logic [COLOR_W-1:0]                  corner_color;
  logic [COLOR_W-1:0]                  edge_color;
  logic                                done_turning;
  logic                                send_setup_moves;
  logic [IdxW-1:0]                     step_index;
  logic                                busy;
  logic                                scan_done;
  logic                                cube_valid;
  logic                                bad_color;
  logic                                error;
  logic [(NUM_STICKERS+6)*COLOR_W-1:0] cubestate;

  modport master (
    output start, corner_color, edge_color, done_turning,
    input  send_setup_moves, step_index, busy, scan_done, cube_valid, bad_color, error,
           cubestate
  );

  modport slave (
    input  start, corner_color, edge_color, done_turning,
    output send_setup_moves, step_index, busy, scan_done, cube_valid, bad_color, error,
           cubestate
  );
endinterface

// File: rtl/cube_scan_sequencer.sv
// Cube scan sequencer: per sticker, request setup moves, wait for the motors plus settle time,
// then sample the corner/edge sensor into cubestate. Define CUBE_SCAN_VOTE_EN for 3-read voting.
module cube_scan_sequencer #(
  parameter int unsigned COLOR_W        = 3,
  parameter int unsigned NUM_STICKERS   = 48,
  parameter int unsigned CORNER_COUNT   = 24,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input logic                  clock,
  input logic                  reset_n,
  cube_scan_sequencer_if.slave bus
);
  localparam int unsigned IdxW = (NUM_STICKERS > 1) ? $clog2(NUM_STICKERS) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 4);
  localparam int unsigned StW  = NUM_STICKERS * COLOR_W;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_STICKERS - 1);
  // Counter value at which the next idle WAIT_MOVE edge becomes a timeout.
  localparam logic [CntW-1:0] TmoLast =
      CntW'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0);
  localparam logic [CntW-1:0] SetLast =
      CntW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  function automatic logic [6*COLOR_W-1:0] center_codes();
    center_codes = '0;
    for (int c = 0; c < 6; c++) begin
      center_codes[c*COLOR_W +: COLOR_W] = COLOR_W'(c);
    end
  endfunction

  localparam logic [6*COLOR_W-1:0] Centers = center_codes();

  typedef enum logic [2:0] {
    StIdle, StPrep, StWaitMove, StSettle, StSample, StDone, StError
  } state_e;

  state_e             state_q;
  logic [IdxW-1:0]    k_q;
  logic [CntW-1:0]    cnt_q;
  logic [StW-1:0]     stickers_q;
  logic               send_q, busy_q, done_q, valid_q, bad_q, err_q;

  logic [COLOR_W-1:0] sensor;
  logic [COLOR_W-1:0] pick;
  logic               split;
  int unsigned        base;

  always_comb begin
    sensor = (32'(k_q) < CORNER_COUNT) ? bus.corner_color : bus.edge_color;
    base   = 32'(k_q) * COLOR_W;
  end

`ifdef CUBE_SCAN_VOTE_EN
  localparam logic [CntW-1:0] SampleLast = CntW'(2);

  logic [COLOR_W-1:0] read0_q, read1_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read0_q <= '0;
      read1_q <= '0;
    end else if (state_q == StSample) begin
      if (cnt_q == CntW'(0)) read0_q <= sensor;
      if (cnt_q == CntW'(1)) read1_q <= sensor;
    end
  end

  // Third reading is the live sensor value; three-way disagreement keeps it but flags it.
  always_comb begin
    pick  = sensor;
    split = 1'b0;
    if (read0_q == read1_q || read0_q == sensor) begin
      pick = read0_q;
    end else if (read1_q == sensor) begin
      pick = read1_q;
    end else begin
      split = 1'b1;
    end
  end
`else
  localparam logic [CntW-1:0] SampleLast = '0;

  assign pick  = sensor;
  assign split = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      cnt_q      <= '0;
      stickers_q <= '0;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      send_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (bus.start) begin
            stickers_q <= '0;
            valid_q    <= 1'b0;
            bad_q      <= 1'b0;
            err_q      <= 1'b0;
            k_q        <= '0;
            send_q     <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StPrep;
          end
        end
        StPrep: begin
          cnt_q   <= '0;
          state_q <= StWaitMove;
        end
        StWaitMove: begin
          if (bus.done_turning) begin
            cnt_q   <= '0;
            state_q <= (SETTLE_CYCLES == 0) ? StSample : StSettle;
          end else if (cnt_q == TmoLast) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StError;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSettle: begin
          if (cnt_q == SetLast) begin
            cnt_q   <= '0;
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSample: begin
          if (cnt_q == SampleLast) begin
            stickers_q[base +: COLOR_W] <= pick;
            if (split || 32'(pick) > 32'd5) bad_q <= 1'b1;
            cnt_q <= '0;
            if (k_q == LastIdx) begin
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              k_q     <= k_q + 1'b1;
              send_q  <= 1'b1;
              state_q <= StPrep;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.send_setup_moves = send_q;
  assign bus.step_index       = k_q;
  assign bus.busy             = busy_q;
  assign bus.scan_done        = done_q;
  assign bus.cube_valid       = valid_q;
  assign bus.bad_color        = bad_q;
  assign bus.error            = err_q;
  assign bus.cubestate        = {Centers, stickers_q};
endmodule

// File: tb/tb_cube_scan_sequencer.sv
// Scoreboard bench for cube_scan_sequencer: a motor/sensor model pushes the expected code for
// each sticker at its setup-move request; scenario tasks pop and compare after scan_done.
module tb_cube_scan_sequencer;
  localparam int CW = 3;
  localparam int NS = 4;
  localparam int CC = 2;
  localparam int SC = 2;
  localparam int TO = 8;
  localparam int IW = $clog2(NS);
`ifdef CUBE_SCAN_VOTE_EN
  localparam int SampleCyc = 3;
`else
  localparam int SampleCyc = 1;
`endif
  localparam int Lat = 1 + 3 + SC + SampleCyc;

  logic clock;
  logic reset_n;
  logic motor_done;
  logic force_done;

  cube_scan_sequencer_if #(.COLOR_W(CW), .NUM_STICKERS(NS)) bus ();

  cube_scan_sequencer #(
    .COLOR_W       (CW),
    .NUM_STICKERS  (NS),
    .CORNER_COUNT  (CC),
    .SETTLE_CYCLES (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  assign bus.done_turning = motor_done | force_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses = 0;
  int prep_cyc = 0;
  bit motor_en = 1'b1;
  bit bad_edge2 = 1'b0;
  bit exp_bad = 1'b0;
  logic [CW-1:0] exp_q[$];
  logic [(NS+6)*CW-1:0] reset_exp;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

`ifdef CUBE_SCAN_VOTE_EN
  logic [CW-1:0] vote_seq [2][3] = '{'{3'd3, 3'd1, 3'd3}, '{3'd1, 3'd2, 3'd4}};
`endif

  // Motor and sensor model: answers each setup request 3 cycles later.
  int idx;
  logic [CW-1:0] e, va, vb, vc;
  initial begin
    motor_done = 1'b0;
    bus.corner_color = 3'd3;
    bus.edge_color = 3'd5;
    forever begin
      @(negedge clock);
      if (reset_n && bus.send_setup_moves) begin
        idx = pulses;
        pulses++;
        prep_cyc = cyc;
        tests++;
        if (bus.step_index !== IW'(idx))
          begin fails++; $display("FAIL step_index got %0d want %0d", bus.step_index, idx); end
        bus.corner_color = 3'd3;
        bus.edge_color = (bad_edge2 && idx == 2) ? 3'd7 : 3'd5;
        if (idx < CC) begin
`ifdef CUBE_SCAN_VOTE_EN
          va = vote_seq[idx][0]; vb = vote_seq[idx][1]; vc = vote_seq[idx][2];
          if (va == vb || va == vc) e = va;
          else if (vb == vc) e = vb;
          else begin e = vc; exp_bad = 1'b1; end
`else
          e = 3'd3;
`endif
        end else begin
          e = bus.edge_color;
        end
        if (e > 3'd5) exp_bad = 1'b1;
        exp_q.push_back(e);
        if (motor_en) begin
          repeat (3) @(negedge clock);
          motor_done = 1'b1;
          @(negedge clock);
          motor_done = 1'b0;
`ifdef CUBE_SCAN_VOTE_EN
          if (idx < CC) begin
            repeat (2) @(negedge clock);
            bus.corner_color = vote_seq[idx][0];
            @(negedge clock);
            bus.corner_color = vote_seq[idx][1];
            @(negedge clock);
            bus.corner_color = vote_seq[idx][2];
          end
`endif
        end
      end
    end
  end

  task automatic do_start();
    pulses = 0;
    exp_q.delete();
    exp_bad = 1'b0;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic run_until_done(output bit seen, output int at);
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (bus.scan_done) begin seen = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    tests++;
    if ({bus.busy, bus.send_setup_moves, bus.scan_done, bus.cube_valid, bus.bad_color,
         bus.error} !== 6'b0)
      begin fails++; $display("FAIL reset_flags got %b want 000000", {bus.busy,
        bus.send_setup_moves, bus.scan_done, bus.cube_valid, bus.bad_color, bus.error}); end
    tests++;
    if (bus.step_index !== '0)
      begin fails++; $display("FAIL reset_step got %0d want 0", bus.step_index); end
    tests++;
    if (bus.cubestate !== reset_exp)
      begin fails++; $display("FAIL reset_cube got %h want %h", bus.cubestate, reset_exp); end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if (bus.busy !== 1'b0 || bus.send_setup_moves !== 1'b0)
      begin fails++; $display("FAIL idle_hold busy=%b send=%b want 0 0", bus.busy,
        bus.send_setup_moves); end
  endtask

  task automatic test_full_scan();
    bit seen;
    int at;
    logic [CW-1:0] want;
    do_start();
    run_until_done(seen, at);
    tests++;
    if (!seen) begin fails++; $display("FAIL full_done got none want scan_done"); end
    tests++;
    if (pulses != NS) begin fails++; $display("FAIL full_pulses got %0d want %0d", pulses, NS); end
    tests++;
    if (at - prep_cyc != Lat)
      begin fails++; $display("FAIL full_latency got %0d want %0d", at - prep_cyc, Lat); end
    tests++;
    if (bus.cube_valid !== 1'b1 || bus.busy !== 1'b0)
      begin fails++; $display("FAIL full_status valid=%b busy=%b want 1 0", bus.cube_valid,
        bus.busy); end
    tests++;
    if (exp_q.size() != NS)
      begin fails++; $display("FAIL full_queue got %0d want %0d", exp_q.size(), NS); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      want = exp_q.pop_front();
      tests++;
      if (bus.cubestate[i*CW +: CW] !== want)
        begin fails++; $display("FAIL full_slice%0d got %0d want %0d", i,
          bus.cubestate[i*CW +: CW], want); end
    end
    for (int c = 0; c < 6; c++) begin
      tests++;
      if (bus.cubestate[(NS+c)*CW +: CW] !== CW'(c))
        begin fails++; $display("FAIL center%0d got %0d want %0d", c,
          bus.cubestate[(NS+c)*CW +: CW], c); end
    end
    tests++;
    if (bus.bad_color !== exp_bad)
      begin fails++; $display("FAIL full_bad got %b want %b", bus.bad_color, exp_bad); end
    @(negedge clock);
    tests++;
    if (bus.scan_done !== 1'b0 || bus.cube_valid !== 1'b1)
      begin fails++; $display("FAIL done_pulse done=%b valid=%b want 0 1", bus.scan_done,
        bus.cube_valid); end
  endtask

  task automatic test_bad_color();
    bit seen;
    int at;
    logic [CW-1:0] want;
    bad_edge2 = 1'b1;
    do_start();
    run_until_done(seen, at);
    bad_edge2 = 1'b0;
    tests++;
    if (!seen) begin fails++; $display("FAIL bad_done got none want scan_done"); end
    tests++;
    if (bus.bad_color !== 1'b1)
      begin fails++; $display("FAIL bad_flag got %b want 1", bus.bad_color); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      want = exp_q.pop_front();
      tests++;
      if (bus.cubestate[i*CW +: CW] !== want)
        begin fails++; $display("FAIL bad_slice%0d got %0d want %0d", i,
          bus.cubestate[i*CW +: CW], want); end
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int at;
    logic [CW-1:0] want;
    motor_en = 1'b0;
    do_start();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.error) begin seen = 1'b1; at = cyc; break; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL tmo_error got 0 want 1"); end
    tests++;
    if (at - prep_cyc != TO)
      begin fails++; $display("FAIL tmo_latency got %0d want %0d", at - prep_cyc, TO); end
    repeat (3) @(negedge clock);
    tests++;
    if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.cube_valid !== 1'b0)
      begin fails++; $display("FAIL tmo_hold err=%b busy=%b valid=%b want 1 0 0", bus.error,
        bus.busy, bus.cube_valid); end
    tests++;
    if (bus.cubestate !== reset_exp)
      begin fails++; $display("FAIL tmo_frozen got %h want %h", bus.cubestate, reset_exp); end
    motor_en = 1'b1;
    do_start();
    tests++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1)
      begin fails++; $display("FAIL tmo_restart err=%b busy=%b want 0 1", bus.error,
        bus.busy); end
    run_until_done(seen, at);
    tests++;
    if (!seen) begin fails++; $display("FAIL tmo_rescan got none want scan_done"); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      want = exp_q.pop_front();
      tests++;
      if (bus.cubestate[i*CW +: CW] !== want)
        begin fails++; $display("FAIL tmo_slice%0d got %0d want %0d", i,
          bus.cubestate[i*CW +: CW], want); end
    end
  endtask

  task automatic test_prep_ignore();
    bit seen;
    int at;
    logic [CW-1:0] want;
    motor_en = 1'b0;
    do_start();
    force_done = 1'b1;
    @(negedge clock);
    force_done = 1'b0;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    tests++;
    if (pulses != 1 || bus.send_setup_moves !== 1'b0)
      begin fails++; $display("FAIL ign_pulses got %0d send=%b want 1 0", pulses,
        bus.send_setup_moves); end
    tests++;
    if (bus.busy !== 1'b1 || bus.step_index !== '0 || bus.error !== 1'b0)
      begin fails++; $display("FAIL ign_wait busy=%b step=%0d err=%b want 1 0 0", bus.busy,
        bus.step_index, bus.error); end
    motor_en = 1'b1;
    force_done = 1'b1;
    @(negedge clock);
    force_done = 1'b0;
    run_until_done(seen, at);
    tests++;
    if (!seen) begin fails++; $display("FAIL ign_done got none want scan_done"); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      want = exp_q.pop_front();
      tests++;
      if (bus.cubestate[i*CW +: CW] !== want)
        begin fails++; $display("FAIL ign_slice%0d got %0d want %0d", i,
          bus.cubestate[i*CW +: CW], want); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    do_start();
    n = 1;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clock);
      if (bus.send_setup_moves) n++;
    end
    repeat (4) @(negedge clock);
    tests++;
    if (bus.busy !== 1'b1 || bus.cubestate[CW-1:0] !== exp_q[0])
      begin fails++; $display("FAIL mid_pre busy=%b slice0=%0d want 1 %0d", bus.busy,
        bus.cubestate[CW-1:0], exp_q[0]); end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.step_index !== '0)
      begin fails++; $display("FAIL mid_clear busy=%b step=%0d want 0 0", bus.busy,
        bus.step_index); end
    tests++;
    if (bus.cubestate !== reset_exp)
      begin fails++; $display("FAIL mid_cube got %h want %h", bus.cubestate, reset_exp); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_q.delete();
    repeat (10) @(negedge clock);
    tests++;
    if (bus.busy !== 1'b0 || bus.send_setup_moves !== 1'b0)
      begin fails++; $display("FAIL mid_idle busy=%b send=%b want 0 0", bus.busy,
        bus.send_setup_moves); end
  endtask

`ifdef CUBE_SCAN_VOTE_EN
  task automatic test_vote();
    bit seen;
    int at;
    do_start();
    run_until_done(seen, at);
    tests++;
    if (!seen) begin fails++; $display("FAIL vote_done got none want scan_done"); end
    tests++;
    if (bus.cubestate[CW-1:0] !== 3'd3)
      begin fails++; $display("FAIL vote_major got %0d want 3", bus.cubestate[CW-1:0]); end
    tests++;
    if (bus.cubestate[CW +: CW] !== 3'd4)
      begin fails++; $display("FAIL vote_split got %0d want 4", bus.cubestate[CW +: CW]); end
    tests++;
    if (bus.bad_color !== 1'b1)
      begin fails++; $display("FAIL vote_bad got %b want 1", bus.bad_color); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0;
    force_done = 1'b0;
    reset_exp = '0;
    for (int c = 0; c < 6; c++) reset_exp[(NS+c)*CW +: CW] = CW'(c);
    test_reset();
    test_full_scan();
    test_bad_color();
    test_timeout();
    test_prep_ignore();
    test_reset_mid();
`ifdef CUBE_SCAN_VOTE_EN
    test_vote();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
